// File: rtl/fpga_din_pkg.sv
// Shared types for the DInGen byte-to-word packer.
// Output words are little-endian: byte 0 sits in bits [7:0].
package fpga_din_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;

   typedef logic [7:0]                  din_byte_t;
   typedef logic [8*BYTES_PER_WORD-1:0] din_word_t;

   typedef struct packed {
      din_word_t  data;
      logic [2:0] nbytes;
   } word_entry_t;

endpackage

// File: rtl/fpga_din_packer_fifo.sv
// Output FIFO of packed words.
// When the FIFO is empty the head output reads zero.
module din_word_fifo
   import fpga_din_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_push,
   input  word_entry_t                 i_entry,
   output logic                        o_full,
   input  logic                        i_pop,
   output word_entry_t                 o_head,
   output logic                        o_empty,
   output logic [$clog2(FIFO_DEPTH):0] o_level
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   word_entry_t   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_pop;
   logic          w_push_ok;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == LVL_FULL);
   assign o_level   = r_level;
   assign w_pop     = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_push_ok = i_push && (!o_full || w_pop);
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_entry;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push_ok, w_pop})
            2'b10:   r_level <= r_level + LVL_ONE;
            2'b01:   r_level <= r_level - LVL_ONE;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/fpga_din_packer.sv
// Packs DInGen bytes into 32-bit little-endian words and queues them.
// Flush emits a zero-padded partial word. Overflow is sticky.
module fpga_din_packer #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned BYTES_PER_WORD = 4
) (
   input  logic                          Clk,
   input  logic                          nReset,
   input  logic                          DInValid,
   input  logic [7:0]                    DIn,
   input  logic                          Flush,
   output logic [8*BYTES_PER_WORD-1:0]   WordOut,
   output logic [2:0]                    WordBytes,
   output logic                          WordValid,
   input  logic                          WordReady,
   output logic [$clog2(FIFO_DEPTH):0]   Level,
   output logic                          Overflow,
   input  logic                          ClearOverflow
);

   import fpga_din_pkg::*;

   din_word_t   r_acc;
   din_word_t   w_lanes;
   logic [1:0]  r_idx;
   logic [2:0]  w_cnt;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic        w_drop;
   logic        r_ovf;
   word_entry_t w_entry;
   word_entry_t w_head;

   // The byte arriving this cycle counts toward both completion and flush size.
   always_comb begin
      w_lanes = r_acc;
      if (DInValid) w_lanes[8*r_idx +: 8] = DIn;
      w_cnt          = {1'b0, r_idx} + {2'b00, DInValid};
      w_push         = (DInValid && (r_idx == 2'd3)) || (Flush && (w_cnt != 3'd0));
      w_entry.data   = w_lanes;
      w_entry.nbytes = w_cnt;
   end

   assign w_pop  = !w_empty && WordReady;
   assign w_drop = w_push && w_full && !w_pop;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (w_push) begin
         r_acc <= '0;
         r_idx <= '0;
      end else if (DInValid) begin
         r_acc <= w_lanes;
         r_idx <= r_idx + 2'd1;
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset)            r_ovf <= 1'b0;
      else if (w_drop)        r_ovf <= 1'b1;
      else if (ClearOverflow) r_ovf <= 1'b0;
   end

   din_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (Clk),
      .i_rst_n (nReset),
      .i_push  (w_push),
      .i_entry (w_entry),
      .o_full  (w_full),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_level (Level)
   );

   assign WordOut   = w_head.data;
   assign WordBytes = w_head.nbytes;
   assign WordValid = !w_empty;
   assign Overflow  = r_ovf;

endmodule

// File: tb/tb_fpga_din_packer.sv
// Randomized and directed bench for fpga_din_packer against a queue-based model.
module tb_fpga_din_packer;

   localparam int DEPTH = 4;

   logic        Clk = 1'b0;
   logic        nReset = 1'b0;
   logic        DInValid = 1'b0;
   logic [7:0]  DIn = '0;
   logic        Flush = 1'b0;
   logic        WordReady = 1'b0;
   logic        ClearOverflow = 1'b0;
   logic [31:0] WordOut;
   logic [2:0]  WordBytes;
   logic        WordValid;
   logic [2:0]  Level;
   logic        Overflow;

   int total = 0;
   int bad   = 0;

   logic [7:0]  m_part[$];
   logic [31:0] m_qd[$];
   logic [2:0]  m_qn[$];
   bit          m_ovf = 0;

   fpga_din_packer #(.FIFO_DEPTH(DEPTH), .BYTES_PER_WORD(4)) dut (
      .Clk(Clk), .nReset(nReset), .DInValid(DInValid), .DIn(DIn), .Flush(Flush),
      .WordOut(WordOut), .WordBytes(WordBytes), .WordValid(WordValid),
      .WordReady(WordReady), .Level(Level), .Overflow(Overflow),
      .ClearOverflow(ClearOverflow)
   );

   always #5 Clk = ~Clk;

   task automatic model_reset();
      m_part.delete(); m_qd.delete(); m_qn.delete(); m_ovf = 0;
   endtask

   // Drive one cycle and advance the model; samples land 1ns after the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic f,
                       input logic r, input logic c);
      bit pop, req, drop;
      logic [31:0] w;
      int n;
      DInValid = v; DIn = d; Flush = f; WordReady = r; ClearOverflow = c;
      pop = (m_qd.size() > 0) && r;
      if (v) m_part.push_back(d);
      req = (m_part.size() == 4) || (f && m_part.size() > 0);
      drop = 0;
      w = '0;
      n = m_part.size();
      if (req) begin
         for (int i = 0; i < n; i++) w[8*i +: 8] = m_part[i];
         m_part.delete();
      end
      if (pop) begin void'(m_qd.pop_front()); void'(m_qn.pop_front()); end
      if (req) begin
         if (m_qd.size() < DEPTH) begin m_qd.push_back(w); m_qn.push_back(3'(n)); end
         else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (c) m_ovf = 0;
      @(posedge Clk); #1;
   endtask

   task automatic do_reset();
      nReset = 1'b0;
      DInValid = 0; Flush = 0; WordReady = 0; ClearOverflow = 0;
      model_reset();
      #1;
      @(negedge Clk); nReset = 1'b1;
   endtask

   task automatic test_reset();
      nReset = 1'b0; #2;
      total++;
      if ({WordValid, Level, Overflow, WordOut, WordBytes} !== '0) begin
         bad++;
         $display("FAIL reset: got valid=%b level=%0d ovf=%b out=%h bytes=%0d required all 0",
                  WordValid, Level, Overflow, WordOut, WordBytes);
      end
      do_reset();
   endtask

   task automatic test_basic_word();
      step(1, 8'h11, 0, 1, 0); step(1, 8'h22, 0, 1, 0);
      step(1, 8'h33, 0, 1, 0); step(1, 8'h44, 0, 1, 0);
      total++;
      if (WordValid !== 1'b1 || WordOut !== 32'h44332211 || WordBytes !== 3'd4) begin
         bad++;
         $display("FAIL basic_word: got v=%b %h/%0d required 1 44332211/4", WordValid, WordOut, WordBytes);
      end
      step(0, 8'h00, 0, 1, 0);
      total++;
      if (WordValid !== 1'b0) begin
         bad++; $display("FAIL basic_drain: got valid=%b required 0", WordValid);
      end
   endtask

   task automatic test_flush();
      step(1, 8'hAA, 0, 1, 0); step(1, 8'hBB, 0, 1, 0); step(0, 8'h00, 1, 1, 0);
      total++;
      if (WordValid !== 1'b1 || WordOut !== 32'h0000BBAA || WordBytes !== 3'd2) begin
         bad++;
         $display("FAIL flush_partial: got v=%b %h/%0d required 1 0000bbaa/2", WordValid, WordOut, WordBytes);
      end
      for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 1, 0);
      total++;
      if (WordValid !== 1'b1 || WordOut !== 32'h04030201 || WordBytes !== 3'd4) begin
         bad++;
         $display("FAIL flush_next: got v=%b %h/%0d required 1 04030201/4", WordValid, WordOut, WordBytes);
      end
      step(0, 8'h00, 0, 1, 0);
   endtask

   task automatic test_overflow();
      logic [7:0] b[20];
      logic [31:0] exp;
      for (int i = 0; i < 20; i++) begin
         b[i] = 8'($urandom);
         step(1, b[i], 0, 0, 0);
         if (i == 15) begin
            total++;
            if (Level !== 3'd4 || Overflow !== 1'b0) begin
               bad++; $display("FAIL ovf_full: got level=%0d ovf=%b required 4 0", Level, Overflow);
            end
         end
      end
      total++;
      if (Level !== 3'd4 || Overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_set: got level=%0d ovf=%b required 4 1", Level, Overflow);
      end
      for (int k = 0; k < 4; k++) begin
         exp = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
         total++;
         if (WordValid !== 1'b1 || WordOut !== exp) begin
            bad++; $display("FAIL ovf_drain%0d: got v=%b %h required 1 %h", k, WordValid, WordOut, exp);
         end
         step(0, 8'h00, 0, 1, 0);
      end
      total++;
      if (WordValid !== 1'b0 || Overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_sticky: got v=%b ovf=%b required 0 1", WordValid, Overflow);
      end
      step(0, 8'h00, 0, 0, 1);
      total++;
      if (Overflow !== 1'b0) begin
         bad++; $display("FAIL ovf_clear: got %b required 0", Overflow);
      end
   endtask

   task automatic test_full_pushpop();
      logic [7:0] b[20];
      logic [31:0] exp;
      for (int i = 0; i < 20; i++) begin
         b[i] = 8'($urandom);
         step(1, b[i], 0, (i == 19), 0);
      end
      total++;
      if (Level !== 3'd4 || Overflow !== 1'b0) begin
         bad++; $display("FAIL pushpop_full: got level=%0d ovf=%b required 4 0", Level, Overflow);
      end
      for (int k = 1; k < 5; k++) begin
         exp = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
         total++;
         if (WordValid !== 1'b1 || WordOut !== exp) begin
            bad++; $display("FAIL pushpop_order%0d: got v=%b %h required 1 %h", k, WordValid, WordOut, exp);
         end
         step(0, 8'h00, 0, 1, 0);
      end
   endtask

   task automatic test_flush_third();
      step(1, 8'h01, 0, 0, 0); step(1, 8'h02, 0, 0, 0); step(1, 8'hCC, 1, 0, 0);
      total++;
      if (Level !== 3'd1 || WordOut !== 32'h00CC0201 || WordBytes !== 3'd3) begin
         bad++;
         $display("FAIL flush_third: got level=%0d %h/%0d required 1 00cc0201/3", Level, WordOut, WordBytes);
      end
      step(0, 8'h00, 1, 0, 0);
      total++;
      if (Level !== 3'd1) begin
         bad++; $display("FAIL flush_idle: got level=%0d required 1", Level);
      end
      step(0, 8'h00, 0, 1, 0);
   endtask

   task automatic test_reset_midword();
      for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0, 0);
      nReset = 1'b0; #1;
      total++;
      if (WordValid !== 1'b0 || Level !== 3'd0) begin
         bad++; $display("FAIL async_reset: got v=%b level=%0d required 0 0", WordValid, Level);
      end
      do_reset();
      step(1, 8'hDE, 0, 0, 0); step(1, 8'hAD, 0, 0, 0);
      step(1, 8'hBE, 0, 0, 0); step(1, 8'hEF, 0, 0, 0);
      total++;
      if (Level !== 3'd1 || WordOut !== 32'hEFBEADDE || WordBytes !== 3'd4) begin
         bad++;
         $display("FAIL post_reset_word: got level=%0d %h/%0d required 1 efbeadde/4", Level, WordOut, WordBytes);
      end
      step(0, 8'h00, 0, 1, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
         total++;
         if (WordValid !== (m_qd.size() > 0) || Level !== 3'(m_qd.size()) || Overflow !== m_ovf) begin
            bad++;
            $display("FAIL rand_status@%0d: got v=%b level=%0d ovf=%b required v=%b level=%0d ovf=%b",
                     n, WordValid, Level, Overflow, m_qd.size() > 0, m_qd.size(), m_ovf);
         end else if (m_qd.size() > 0) begin
            total++;
            if (WordOut !== m_qd[0] || WordBytes !== m_qn[0]) begin
               bad++;
               $display("FAIL rand_head@%0d: got %h/%0d required %h/%0d", n, WordOut, WordBytes, m_qd[0], m_qn[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_word();
      test_flush();
      test_overflow();
      test_full_pushpop();
      test_flush_third();
      test_reset_midword();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
